// File: rtl/dsi_ctrl_pkg.sv
// Shared constants and state encodings for the DSI controller register port.
package dsi_ctrl_pkg;

   localparam logic [6:0] STATUS_ADDR = 7'h24;

   localparam int ST_INFLIGHT = 11;
   localparam int ST_PENDING  = 10;
   localparam int ST_TIMEOUT  = 1;
   localparam int ST_ERR      = 0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

endpackage

// File: rtl/dsi_cmd_slot.sv
// Single-entry command slot toward the DSI packet engine: holds one pending
// command until accepted, then tracks it in flight until done or timeout.
module dsi_cmd_slot #(
   parameter logic [21:0] TIMEOUT = 22'd4000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [6:0]  load_addr,
   input  logic [31:0] load_data,
   input  logic        cmd_ready,
   input  logic        cmd_done,
   output logic        cmd_valid,
   output logic [6:0]  cmd_addr,
   output logic [31:0] cmd_data,
   output logic        idle,
   output logic        pending,
   output logic        inflight,
   output logic        timeout_pulse
);

   logic [21:0] count;

   assign pending       = cmd_valid;
   assign idle          = !cmd_valid && !inflight;
   // A done arriving on the expiry cycle suppresses the timeout.
   assign timeout_pulse = inflight && !cmd_done && (count == TIMEOUT - 22'd1);

   // Pending -> in flight -> idle sequencing with the expiry counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid <= 1'b0;
         cmd_addr  <= '0;
         cmd_data  <= '0;
         inflight  <= 1'b0;
         count     <= '0;
      end else begin
         if (load) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= load_addr;
            cmd_data  <= load_data;
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            inflight  <= 1'b1;
            count     <= '0;
         end else if (inflight) begin
            if (cmd_done || timeout_pulse) begin
               inflight <= 1'b0;
            end else begin
               count <= count + 22'd1;
            end
         end
      end
   end

endmodule

// File: rtl/dsi_ctrl_axil_slave.sv
// AXI4-Lite register port of the DSI controller: shadows register writes,
// forwards each one as a command packet, and reports command progress in a
// status register that the host polls.
module dsi_ctrl_axil_slave #(
   parameter int          NUM_REGS    = 9,
   parameter logic [6:0]  STATUS_ADDR = dsi_ctrl_pkg::STATUS_ADDR,
   parameter logic [21:0] TIMEOUT     = 22'd4000000
) (
   input  logic        i_axi_clk,
   input  logic        i_rst,
   input  logic [6:0]  i_axi_awaddr,
   input  logic        i_axi_awvalid,
   output logic        o_axi_awready,
   input  logic [31:0] i_axi_wdata,
   input  logic        i_axi_wvalid,
   output logic        o_axi_wready,
   output logic        o_axi_bvalid,
   output logic [1:0]  o_axi_bresp,
   input  logic        i_axi_bready,
   input  logic [6:0]  i_axi_araddr,
   input  logic        i_axi_arvalid,
   output logic        o_axi_arready,
   output logic [31:0] o_axi_rdata,
   output logic [1:0]  o_axi_rresp,
   output logic        o_axi_rvalid,
   input  logic        i_axi_rready,
   output logic        o_cmd_valid,
   output logic [6:0]  o_cmd_addr,
   output logic [31:0] o_cmd_data,
   input  logic        i_cmd_ready,
   input  logic        i_cmd_done,
   output logic        o_busy
);

   import dsi_ctrl_pkg::*;

   localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

   w_state_t    w_state;
   r_state_t    r_state;
   logic [31:0] shadow [NUM_REGS];
   logic [6:0]  aw_addr;
   logic [31:0] w_data;
   logic        aw_got, w_got, aw_hs, w_hs, aw_mapped;
   logic        commit, load, set_err;
   logic        slot_idle, slot_pending, slot_inflight, timeout_pulse;
   logic        st_timeout, st_err, rd_status_q, status_clear;
   logic [31:0] status_word, rd_value;
   logic [1:0]  rd_resp;
   logic        rd_status;
   logic        unused_araddr_lsb;

   assign aw_hs        = o_axi_awready && i_axi_awvalid;
   assign w_hs         = o_axi_wready && i_axi_wvalid;
   assign aw_mapped    = aw_addr[6:2] < NUM_REGS_W;
   assign commit       = (w_state == W_COMMIT) && slot_idle;
   assign load         = commit && aw_mapped;
   assign set_err      = commit && !aw_mapped;
   assign status_clear = (r_state == R_DATA) && i_axi_rready && rd_status_q;
   assign o_busy       = slot_pending || slot_inflight;

   // Word-aligned accesses only; the byte offset bits of a read address carry no meaning.
   assign unused_araddr_lsb = ^i_axi_araddr[1:0];

   dsi_cmd_slot #(.TIMEOUT(TIMEOUT)) u_slot (
      .clk           (i_axi_clk),
      .rst           (i_rst),
      .load          (load),
      .load_addr     (aw_addr),
      .load_data     (w_data),
      .cmd_ready     (i_cmd_ready),
      .cmd_done      (i_cmd_done),
      .cmd_valid     (o_cmd_valid),
      .cmd_addr      (o_cmd_addr),
      .cmd_data      (o_cmd_data),
      .idle          (slot_idle),
      .pending       (slot_pending),
      .inflight      (slot_inflight),
      .timeout_pulse (timeout_pulse)
   );

   // Assemble the status word from live slot flags and the sticky bits.
   always_comb begin
      status_word              = '0;
      status_word[ST_INFLIGHT] = slot_inflight;
      status_word[ST_PENDING]  = slot_pending;
      status_word[ST_TIMEOUT]  = st_timeout;
      status_word[ST_ERR]      = st_err;
   end

   // Decode the read address into the value and response to latch at AR handshake.
   always_comb begin
      rd_value  = '0;
      rd_resp   = RESP_SLVERR;
      rd_status = 1'b0;
      if (i_axi_araddr[6:2] < NUM_REGS_W) begin
         rd_resp = RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i_axi_araddr[6:2] == 5'(i)) begin
               rd_value = shadow[i];
            end
         end
      end else if (i_axi_araddr[6:2] == STATUS_ADDR[6:2]) begin
         rd_value  = status_word;
         rd_resp   = RESP_OKAY;
         rd_status = 1'b1;
      end
   end

   // Write channel: collect AW and W in any order, wait for a free slot, respond.
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         w_state       <= W_IDLE;
         o_axi_awready <= 1'b0;
         o_axi_wready  <= 1'b0;
         o_axi_bvalid  <= 1'b0;
         o_axi_bresp   <= RESP_OKAY;
         aw_got        <= 1'b0;
         w_got         <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  o_axi_awready <= 1'b0;
                  aw_got        <= 1'b1;
                  aw_addr       <= i_axi_awaddr;
               end else if (!aw_got) begin
                  o_axi_awready <= 1'b1;
               end
               if (w_hs) begin
                  o_axi_wready <= 1'b0;
                  w_got        <= 1'b1;
                  w_data       <= i_axi_wdata;
               end else if (!w_got) begin
                  o_axi_wready <= 1'b1;
               end
               if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                  w_state <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               if (slot_idle) begin
                  o_axi_bvalid <= 1'b1;
                  o_axi_bresp  <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
                  w_state      <= W_RESP;
               end
            end
            W_RESP: begin
               if (i_axi_bready) begin
                  o_axi_bvalid  <= 1'b0;
                  aw_got        <= 1'b0;
                  w_got         <= 1'b0;
                  o_axi_awready <= 1'b1;
                  o_axi_wready  <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Shadow registers take the write data when a mapped write commits.
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_addr[6:2] == 5'(i)) begin
               shadow[i] <= w_data;
            end
         end
      end
   end

   // Sticky error flags; a new event outranks a read-clear in the same cycle.
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         st_timeout <= 1'b0;
         st_err     <= 1'b0;
      end else begin
         if (timeout_pulse) begin
            st_timeout <= 1'b1;
         end else if (status_clear) begin
            st_timeout <= 1'b0;
         end
         if (set_err) begin
            st_err <= 1'b1;
         end else if (status_clear) begin
            st_err <= 1'b0;
         end
      end
   end

   // Read channel: latch data at AR handshake and hold it until R handshake.
   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         r_state       <= R_IDLE;
         o_axi_arready <= 1'b0;
         o_axi_rvalid  <= 1'b0;
         o_axi_rdata   <= '0;
         o_axi_rresp   <= RESP_OKAY;
         rd_status_q   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (o_axi_arready && i_axi_arvalid) begin
                  o_axi_arready <= 1'b0;
                  o_axi_rvalid  <= 1'b1;
                  o_axi_rdata   <= rd_value;
                  o_axi_rresp   <= rd_resp;
                  rd_status_q   <= rd_status;
                  r_state       <= R_DATA;
               end else begin
                  o_axi_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (i_axi_rready) begin
                  o_axi_rvalid  <= 1'b0;
                  o_axi_arready <= 1'b1;
                  rd_status_q   <= 1'b0;
                  r_state       <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule
